// File: rtl/maxnet_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | maxnet_sequencer: sequences MaxNet lateral-inhibition micro-ops on a shared |
// | FP unit until one neuron survives. Revision 1.0                            |
// +----------------------------------------------------------------------------+
module maxnet_sequencer #(
    parameter int N        = 4,
    parameter int MAX_ITER = 32,
    parameter int IW       = 8,
    localparam int SW      = $clog2(N + 3),
    localparam int WW      = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  nz,
    input  logic          fp_ack,
    output logic          load_x,
    output logic          fp_req,
    output logic [1:0]    fp_op,
    output logic [SW-1:0] src_a,
    output logic [SW-1:0] src_b,
    output logic [SW-1:0] dst,
    output logic          commit,
    output logic          busy,
    output logic          done,
    output logic [WW-1:0] winner,
    output logic          no_winner,
    output logic          timeout,
    output logic [IW-1:0] iter_count
);

    localparam int NOPS = 4 * N - 1;
    localparam int KW   = $clog2(NOPS + 1);
    localparam int PW   = $clog2(N + 1);

    localparam logic [1:0]    c_OP_ADD  = 2'd0;
    localparam logic [1:0]    c_OP_SUB  = 2'd1;
    localparam logic [1:0]    c_OP_MUL  = 2'd2;
    localparam logic [SW-1:0] c_SEL_SUM = SW'(N);
    localparam logic [SW-1:0] c_SEL_TMP = SW'(N + 1);
    localparam logic [SW-1:0] c_SEL_EPS = SW'(N + 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_ISSUE  = 3'd4,
        S_GAP    = 3'd5,
        S_COMMIT = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_k;
    logic [WW-1:0] r_j;
    logic [1:0]    r_ph;
    logic [IW-1:0] r_iter;
    logic [WW-1:0] r_winner;
    logic          r_no_winner;
    logic          r_timeout;

    logic [PW-1:0] w_pop;
    logic [WW-1:0] w_idx;
    logic          w_last;
    logic          w_at_limit;

    always_comb begin
        w_pop = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (nz[i]) begin
                w_pop = w_pop + PW'(1);
                w_idx = WW'(i);
            end
        end
    end

    assign w_last     = (r_k == KW'(NOPS - 1));
    assign w_at_limit = (r_iter == IW'(MAX_ITER));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        load_x = 1'b0;
        fp_req = 1'b0;
        fp_op  = '0;
        src_a  = '0;
        src_b  = '0;
        dst    = '0;
        commit = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_next = S_LOAD;
            S_LOAD: begin
                load_x = 1'b1;
                w_next = S_SETTLE;
            end
            S_SETTLE: w_next = S_CHECK;
            S_CHECK: begin
                if (w_pop <= PW'(1) || w_at_limit) w_next = S_DONE;
                else                               w_next = S_ISSUE;
            end
            S_ISSUE: begin
                fp_req = 1'b1;
                if (fp_ack) w_next = w_last ? S_COMMIT : S_GAP;
                // Accumulate the total first, then inhibit each neuron by eps*(others).
                if (r_k < KW'(N - 1)) begin
                    fp_op = c_OP_ADD;
                    src_a = (r_k == '0) ? '0 : c_SEL_SUM;
                    src_b = SW'(r_k) + SW'(1);
                    dst   = c_SEL_SUM;
                end else begin
                    case (r_ph)
                        2'd0: begin
                            fp_op = c_OP_SUB;
                            src_a = c_SEL_SUM;
                            src_b = SW'(r_j);
                            dst   = c_SEL_TMP;
                        end
                        2'd1: begin
                            fp_op = c_OP_MUL;
                            src_a = c_SEL_EPS;
                            src_b = c_SEL_TMP;
                            dst   = c_SEL_TMP;
                        end
                        default: begin
                            fp_op = c_OP_SUB;
                            src_a = SW'(r_j);
                            src_b = c_SEL_TMP;
                            dst   = SW'(r_j);
                        end
                    endcase
                end
            end
            S_GAP: w_next = S_ISSUE;
            S_COMMIT: begin
                commit = 1'b1;
                w_next = S_SETTLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k         <= '0;
            r_j         <= '0;
            r_ph        <= '0;
            r_iter      <= '0;
            r_winner    <= '0;
            r_no_winner <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_iter      <= '0;
                        r_winner    <= '0;
                        r_no_winner <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                S_CHECK: begin
                    r_k  <= '0;
                    r_j  <= '0;
                    r_ph <= '0;
                    if (w_pop == PW'(1)) begin
                        r_winner <= w_idx;
                    end else if (w_pop == '0) begin
                        r_no_winner <= 1'b1;
                        r_winner    <= '0;
                    end else if (w_at_limit) begin
                        r_timeout <= 1'b1;
                        r_winner  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (fp_ack && !w_last) begin
                        r_k <= r_k + KW'(1);
                        if (r_k >= KW'(N - 1)) begin
                            if (r_ph == 2'd2) begin
                                r_ph <= 2'd0;
                                r_j  <= r_j + WW'(1);
                            end else begin
                                r_ph <= r_ph + 2'd1;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    if (r_iter != '1) r_iter <= r_iter + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign winner     = r_winner;
    assign no_winner  = r_no_winner;
    assign timeout    = r_timeout;
    assign iter_count = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_maxnet_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_maxnet_sequencer: directed and randomized bench with a behavioural model |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_maxnet_sequencer;

    localparam int N        = 4;
    localparam int MAX_ITER = 2;
    localparam int IW       = 8;
    localparam int SW       = $clog2(N + 3);
    localparam int WW       = $clog2(N);
    localparam int NOPS     = 4 * N - 1;
    localparam int VW       = 9 + 3 * SW + WW + IW;
    localparam int OW       = 2 + 3 * SW;

    localparam int M_IDLE = 0, M_LOAD = 1, M_SETTLE = 2, M_CHECK = 3;
    localparam int M_ISSUE = 4, M_GAP = 5, M_COMMIT = 6, M_DONE = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  nz;
    logic          fp_ack = 1'b0;
    logic          load_x, fp_req, commit, busy, done, no_winner, timeout;
    logic [1:0]    fp_op;
    logic [SW-1:0] src_a, src_b, dst;
    logic [WW-1:0] winner;
    logic [IW-1:0] iter_count;

    maxnet_sequencer #(.N(N), .MAX_ITER(MAX_ITER), .IW(IW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .nz(nz), .fp_ack(fp_ack),
        .load_x(load_x), .fp_req(fp_req), .fp_op(fp_op),
        .src_a(src_a), .src_b(src_b), .dst(dst), .commit(commit),
        .busy(busy), .done(done), .winner(winner), .no_winner(no_winner),
        .timeout(timeout), .iter_count(iter_count)
    );

    always #5 clk = ~clk;

    // Expected micro-op list, built from the iteration's arithmetic.
    logic [1:0]    t_op [NOPS];
    logic [SW-1:0] t_a  [NOPS];
    logic [SW-1:0] t_b  [NOPS];
    logic [SW-1:0] t_d  [NOPS];

    int            ms = M_IDLE;
    int            mk = 0;
    int            mwin = 0;
    logic [IW-1:0] miter = '0;
    logic          mnw = 1'b0, mto = 1'b0;

    function automatic int lowest_set(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ms <= M_IDLE; mk <= 0; miter <= '0; mwin <= 0; mnw <= 1'b0; mto <= 1'b0;
        end else begin
            case (ms)
                M_IDLE, M_DONE: if (start) begin
                    ms <= M_LOAD; miter <= '0; mwin <= 0; mnw <= 1'b0; mto <= 1'b0;
                end
                M_LOAD:   ms <= M_SETTLE;
                M_SETTLE: ms <= M_CHECK;
                M_CHECK: begin
                    if ($countones(nz) == 1) begin
                        ms <= M_DONE; mwin <= lowest_set(nz);
                    end else if ($countones(nz) == 0) begin
                        ms <= M_DONE; mnw <= 1'b1;
                    end else if (miter == IW'(MAX_ITER)) begin
                        ms <= M_DONE; mto <= 1'b1;
                    end else begin
                        ms <= M_ISSUE; mk <= 0;
                    end
                end
                M_ISSUE: if (fp_ack) begin
                    if (mk == NOPS - 1) ms <= M_COMMIT;
                    else begin ms <= M_GAP; mk <= mk + 1; end
                end
                M_GAP:    ms <= M_ISSUE;
                M_COMMIT: begin
                    ms <= M_SETTLE;
                    if (miter != '1) miter <= miter + IW'(1);
                end
                default:  ms <= M_IDLE;
            endcase
        end
    end

    // FP unit stand-in: acks after cur_lat request cycles, optional stray acks.
    int rq_cyc = 0;
    int cur_lat = 1;
    int lat_mode = 1;
    bit spur_en = 1'b0;

    always @(negedge clk) begin
        if (fp_req) begin
            rq_cyc <= rq_cyc + 1;
            fp_ack <= (rq_cyc + 1 >= cur_lat);
        end else begin
            rq_cyc  <= 0;
            cur_lat <= (lat_mode == 0) ? int'($urandom_range(1, 3)) : lat_mode;
            fp_ack  <= spur_en && ($urandom_range(0, 1) == 1);
        end
    end

    logic [OW-1:0] oplog[$];
    always @(posedge clk) begin
        if (!rst && fp_req && fp_ack) oplog.push_back({fp_op, src_a, src_b, dst});
    end

    int checks = 0, errors = 0;
    int n_load = 0, n_commit = 0;

    function automatic logic [VW-1:0] dut_vec();
        return {load_x, fp_req, fp_op, src_a, src_b, dst, commit, busy, done,
                winner, no_winner, timeout, iter_count};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic iss;
        iss = (ms == M_ISSUE);
        return {ms == M_LOAD, iss,
                iss ? t_op[mk] : 2'd0,
                iss ? t_a[mk] : SW'(0),
                iss ? t_b[mk] : SW'(0),
                iss ? t_d[mk] : SW'(0),
                ms == M_COMMIT, !(ms == M_IDLE || ms == M_DONE), ms == M_DONE,
                WW'(mwin), mnw, mto, miter};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    task automatic tick();
        logic [VW-1:0] g, e;
        @(negedge clk);
        g = dut_vec();
        e = model_vec();
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL cycle_compare t=%0t got=%h expected=%h", $time, g, e);
        end
        if (load_x) n_load++;
        if (commit) n_commit++;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc, base, idx, rst_at;
        bit aborted;

        for (int k = 0; k < N - 1; k++) begin
            t_op[k] = 2'd0;
            t_a[k]  = (k == 0) ? SW'(0) : SW'(N);
            t_b[k]  = SW'(k + 1);
            t_d[k]  = SW'(N);
        end
        for (int j = 0; j < N; j++) begin
            idx = N - 1 + 3 * j;
            t_op[idx]   = 2'd1; t_a[idx]   = SW'(N);     t_b[idx]   = SW'(j);     t_d[idx]   = SW'(N + 1);
            t_op[idx+1] = 2'd2; t_a[idx+1] = SW'(N + 2); t_b[idx+1] = SW'(N + 1); t_d[idx+1] = SW'(N + 1);
            t_op[idx+2] = 2'd1; t_a[idx+2] = SW'(j);     t_b[idx+2] = SW'(N + 1); t_d[idx+2] = SW'(j);
        end

        // Reset behaviour
        rst = 1'b1; start = 1'b0; nz = '0;
        repeat (3) tick();
        chk("reset_outputs", 32'(dut_vec()), 32'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Already-resolved input: one survivor before any iteration
        n_load = 0; base = oplog.size();
        do_start();
        nz = 4'b0100; cyc = 1;
        while (!done && cyc < 50) begin tick(); cyc++; end
        chk("pre_done_latency", 32'(cyc), 32'd4);
        chk("pre_load_pulses", 32'(n_load), 32'd1);
        chk("pre_no_requests", 32'(oplog.size() - base), 32'd0);
        chk("pre_winner", 32'(winner), 32'd2);
        chk("pre_iter", 32'(iter_count), 32'd0);
        repeat (2) tick();
        chk("pre_done_held", 32'(done), 32'd1);

        // One full iteration with a two-cycle ack latency
        lat_mode = 2; n_commit = 0; base = oplog.size();
        do_start();
        nz = 4'b1111; cyc = 1;
        while (!commit && cyc < 200) begin tick(); cyc++; end
        chk("iter_commit_cycle", 32'(cyc), 32'd48);
        nz = 4'b1000;
        while (!done && cyc < 400) begin tick(); cyc++; end
        chk("iter_req_count", 32'(oplog.size() - base), 32'(NOPS));
        if (oplog.size() - base == NOPS) begin
            chk("iter_op_first", 32'(oplog[base]),      32'({2'd0, 3'd0, 3'd1, 3'd4}));
            chk("iter_op_3",     32'(oplog[base + 3]),  32'({2'd1, 3'd4, 3'd0, 3'd5}));
            chk("iter_op_4",     32'(oplog[base + 4]),  32'({2'd2, 3'd6, 3'd5, 3'd5}));
            chk("iter_op_last",  32'(oplog[base + 14]), 32'({2'd1, 3'd3, 3'd5, 3'd3}));
            for (int i = 0; i < NOPS; i++)
                chk("iter_op_seq", 32'(oplog[base + i]), 32'({t_op[i], t_a[i], t_b[i], t_d[i]}));
        end
        chk("iter_commits", 32'(n_commit), 32'd1);
        chk("iter_winner", 32'(winner), 32'd3);
        chk("iter_count_1", 32'(iter_count), 32'd1);

        // Iteration limit reached with several survivors
        lat_mode = 1; n_commit = 0;
        do_start();
        nz = 4'b1111; cyc = 1;
        while (!done && cyc < 400) begin tick(); cyc++; end
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_iter", 32'(iter_count), 32'd2);
        chk("to_commits", 32'(n_commit), 32'd2);
        chk("to_winner", 32'(winner), 32'd0);

        // Every neuron driven to zero
        do_start();
        nz = 4'b1111; cyc = 1;
        while (!commit && cyc < 200) begin tick(); cyc++; end
        nz = 4'b0000;
        while (!done && cyc < 400) begin tick(); cyc++; end
        chk("zero_no_winner", 32'(no_winner), 32'd1);
        chk("zero_winner", 32'(winner), 32'd0);
        chk("zero_timeout", 32'(timeout), 32'd0);

        // Start while busy and stray acks in the gaps
        lat_mode = 0; spur_en = 1'b1; n_commit = 0;
        do_start();
        nz = 4'b1111;
        repeat (10) tick();
        start = 1'b1; tick(); start = 1'b0;
        cyc = 12;
        while (!commit && cyc < 300) begin tick(); cyc++; end
        nz = 4'b0001;
        while (!done && cyc < 400) begin tick(); cyc++; end
        chk("rob_done", 32'(done), 32'd1);
        chk("rob_winner", 32'(winner), 32'd0);
        chk("rob_commits", 32'(n_commit), 32'd1);

        // Reset in the middle of a request
        do_start();
        nz = 4'b1111; cyc = 1;
        while (!fp_req && cyc < 50) begin tick(); cyc++; end
        chk("rst_saw_req", 32'(fp_req), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_req", 32'({fp_req, commit, load_x, busy}), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_start();
        nz = 4'b0010; cyc = 1;
        while (!done && cyc < 50) begin tick(); cyc++; end
        chk("post_rst_winner", 32'(winner), 32'd1);
        chk("post_rst_done", 32'(done), 32'd1);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            rst_at  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(2, 60)) : -1;
            spur_en = ($urandom_range(0, 1) == 1);
            aborted = 1'b0;
            do_start();
            cyc = 0;
            while (!done && cyc < 400) begin
                if (load_x || commit) nz = N'($urandom_range(0, 15));
                start = ($urandom_range(0, 25) == 0);
                if (cyc == rst_at) begin
                    #3 rst = 1'b1;
                    #1 chk("rnd_rst_req", 32'(fp_req), 32'd0);
                    tick();
                    rst = 1'b0;
                    aborted = 1'b1;
                    break;
                end
                tick(); cyc++;
            end
            start = 1'b0;
            if (!aborted) chk("rnd_done", 32'(done), 32'd1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
